// File: rtl/sample_readout.sv
// Read-side controller for the capture sample memory: strobes reads newest-first and hands each
// word to the serial transmitter. Define READOUT_GROUP_MASK_EN to add per-byte group masking.
module sample_readout #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 18,
    parameter int MEM_LATENCY = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [COUNT_WIDTH-1:0]   readCount,
    output logic                     memRead,
    input  logic [DATA_WIDTH-1:0]    memData,
    output logic [DATA_WIDTH-1:0]    txData,
    output logic                     txSend,
    input  logic                     txBusy,
    output logic                     busy,
    output logic                     done
`ifdef READOUT_GROUP_MASK_EN
    ,
    input  logic [DATA_WIDTH/8-1:0]  disabledGroups,
    output logic [DATA_WIDTH/8-1:0]  txByteEn
`endif
);

    localparam int GROUPS = DATA_WIDTH / 8;
    localparam int LAT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [LAT_W-1:0]       LAT_LOAD  = LAT_W'(MEM_LATENCY - 1);
    localparam logic [LAT_W-1:0]       LAT_ONE   = LAT_W'(1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] READ    = 3'd1;
    localparam logic [2:0] WAITMEM = 3'd2;
    localparam logic [2:0] LATCH   = 3'd3;
    localparam logic [2:0] SEND    = 3'd4;
    localparam logic [2:0] SETTLE  = 3'd5;
    localparam logic [2:0] WAITTX  = 3'd6;
    localparam logic [2:0] FINISH  = 3'd7;

    logic [2:0]             state_q, state_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [LAT_W-1:0]       lat_q, lat_d;
    logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
    logic [GROUPS-1:0]      mask_q, mask_d;
    logic [GROUPS-1:0]      byte_en_q, byte_en_d;
    logic [GROUPS-1:0]      start_mask;

`ifdef READOUT_GROUP_MASK_EN
    assign start_mask = disabledGroups;
`else
    assign start_mask = '0;
`endif

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        lat_d       = lat_q;
        tx_data_d   = tx_data_q;
        mask_d      = mask_q;
        byte_en_d   = byte_en_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d    = start_mask;
                    byte_en_d = ~start_mask;
                    if (readCount != '0) begin
                        remaining_d = readCount;
                        state_d     = READ;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            READ: begin
                lat_d   = LAT_LOAD;
                state_d = WAITMEM;
            end
            // The counter is compared before decrementing so WAITMEM lasts MEM_LATENCY-1 cycles.
            WAITMEM: begin
                if (lat_q <= LAT_ONE) begin
                    state_d = LATCH;
                end else begin
                    lat_d = lat_q - LAT_ONE;
                end
            end
            LATCH: begin
                tx_data_d = memData;
                for (int g = 0; g < GROUPS; g++) begin
                    if (mask_q[g]) begin
                        tx_data_d[g*8 +: 8] = 8'h00;
                    end
                end
                remaining_d = remaining_q - COUNT_ONE;
                state_d     = SEND;
            end
            SEND: begin
                if (!txBusy) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                state_d = WAITTX;
            end
            WAITTX: begin
                if (!txBusy) begin
                    state_d = (remaining_q == '0) ? FINISH : READ;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            lat_q       <= '0;
            tx_data_q   <= '0;
            mask_q      <= '0;
            byte_en_q   <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            lat_q       <= lat_d;
            tx_data_q   <= tx_data_d;
            mask_q      <= mask_d;
            byte_en_q   <= byte_en_d;
        end
    end

    // Strobes decode straight from the state register, so reset clears them on the same edge.
    assign memRead = (state_q == READ);
    assign txSend  = (state_q == SEND) && !txBusy;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == FINISH);
    assign txData  = tx_data_q;

`ifdef READOUT_GROUP_MASK_EN
    assign txByteEn = byte_en_q;
`endif

endmodule
